alu_req_unit: RTL and testbench

ALU_REQ_UNIT -- requirements
Module: alu_req_unit

---
 rtl/alu_pkg.sv | 11 +
 rtl/alu_req_unit_if.sv | 26 ++
 rtl/alu_req_unit.sv | 71 +++++++
 tb/tb_alu_req_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared FSM states and constants for the ALU request unit
package alu_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_NUM_OPS = 10;
  localparam int SEL_W = 4;
  localparam int CNT_W = 2;
  function automatic logic sel_legal(logic [SEL_W-1:0] sel, int num_ops);
    return 32'(sel) < 32'(num_ops);
  endfunction
endpackage

// File: rtl/alu_req_unit_if.sv
// alu_req_unit_if: request/response handshake bundle between a requester and the ALU request unit
interface alu_req_unit_if #(
  parameter int WIDTH = alu_pkg::DEF_WIDTH,
  parameter int TAG_W = 4
);
  logic req_valid;
  logic req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [alu_pkg::SEL_W-1:0] req_sel;
  logic [TAG_W-1:0] req_tag;
  logic rsp_valid;
  logic rsp_ready;
  logic [WIDTH-1:0] rsp_res;
  logic [TAG_W-1:0] rsp_tag;
  logic rsp_zero;
  logic rsp_err;
  modport master (
    output req_valid, req_a, req_b, req_sel, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_res, rsp_tag, rsp_zero, rsp_err
  );
  modport slave (
    input  req_valid, req_a, req_b, req_sel, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_res, rsp_tag, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_req_unit.sv
// alu_req_unit: accepts tagged ALU requests, drives a registered external ALU and returns the tagged result
module alu_req_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAG_W = 4,
  parameter int LAT = 1,
  parameter int NUM_OPS = DEF_NUM_OPS
) (
  input  logic clk,
  input  logic rst,
  alu_req_unit_if.slave bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_res,
  output logic busy,
  output logic [15:0] ops_done
);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic acc, legal, rsp_hs;
  assign bus.rsp_valid = state == RESP;
  assign busy = state != IDLE;
  // a completing response frees the unit in the same cycle, so a new request can ride on it
  always_comb begin
    bus.req_ready = !rst && (state == IDLE || (state == RESP && bus.rsp_ready));
    acc = bus.req_valid && bus.req_ready;
    legal = sel_legal(bus.req_sel, NUM_OPS);
    rsp_hs = bus.rsp_valid && bus.rsp_ready;
    state_nx = acc ? (legal ? EXEC : RESP)
             : state == EXEC ? (cnt == '0 ? RESP : EXEC)
             : rsp_hs ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_sel <= '0;
      bus.rsp_res <= '0;
      bus.rsp_tag <= '0;
      bus.rsp_zero <= 1'b0;
      bus.rsp_err <= 1'b0;
      ops_done <= '0;
    end else begin
      state <= state_nx;
      if (rsp_hs) ops_done <= ops_done + 16'd1;
      if (acc) begin
        bus.rsp_tag <= bus.req_tag;
        if (legal) begin
          alu_a <= bus.req_a;
          alu_b <= bus.req_b;
          alu_sel <= bus.req_sel;
          cnt <= CNT_W'(LAT - 1);
        end else begin
          bus.rsp_res <= '0;
          bus.rsp_zero <= 1'b0;
          bus.rsp_err <= 1'b1;
        end
      end else if (state == EXEC) begin
        if (cnt == '0) begin
          bus.rsp_res <= alu_res;
          bus.rsp_zero <= alu_res == '0;
          bus.rsp_err <= 1'b0;
        end else cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_req_unit.sv
// tb_alu_req_unit: runs LAT=1 and LAT=3 units side by side against a timestamp-based transaction model
module tb_alu_req_unit;
  localparam int W = 32;
  localparam int TW = 4;
  typedef struct {
    logic [W-1:0] a, b;
    logic [3:0] sel;
    logic [TW-1:0] tag;
    logic [W-1:0] res;
    bit zero, err;
  } vec_t;
  logic clk = 1'b0;
  logic rst, req_valid, rsp_ready;
  logic [W-1:0] req_a, req_b;
  logic [3:0] req_sel;
  logic [TW-1:0] req_tag;
  logic [W-1:0] alu_a [2], alu_b [2], alu_res [2], rr [2];
  logic [3:0] alu_sel [2];
  logic [15:0] ops_done [2];
  logic [TW-1:0] rt [2];
  logic busy [2], rdy [2], rv [2], rz [2], re [2];
  int nvec = 0, nfail = 0, cyc = 0;
  bit m_have [2], m_zero [2], m_err [2];
  int m_at [2];
  logic [W-1:0] m_res [2], m_a [2], m_b [2];
  logic [3:0] m_sel [2];
  logic [TW-1:0] m_tag [2];
  logic [15:0] m_ops [2];
  logic [3:0] last_sel;
  always #5 clk = ~clk;
  alu_req_unit_if #(.WIDTH(W), .TAG_W(TW)) bus [2] ();
  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : du
      assign bus[g].req_valid = req_valid;
      assign bus[g].req_a = req_a;
      assign bus[g].req_b = req_b;
      assign bus[g].req_sel = req_sel;
      assign bus[g].req_tag = req_tag;
      assign bus[g].rsp_ready = rsp_ready;
      assign alu_res[g] = alu_a[g] + alu_b[g];
      assign rdy[g] = bus[g].req_ready;
      assign rv[g] = bus[g].rsp_valid;
      assign rr[g] = bus[g].rsp_res;
      assign rt[g] = bus[g].rsp_tag;
      assign rz[g] = bus[g].rsp_zero;
      assign re[g] = bus[g].rsp_err;
      alu_req_unit #(.WIDTH(W), .TAG_W(TW), .LAT(g == 0 ? 1 : 3), .NUM_OPS(10)) dut (
        .clk(clk), .rst(rst), .bus(bus[g]),
        .alu_a(alu_a[g]), .alu_b(alu_b[g]), .alu_sel(alu_sel[g]), .alu_res(alu_res[g]),
        .busy(busy[g]), .ops_done(ops_done[g])
      );
    end
  endgenerate
  function automatic int lat(int d);
    return d == 0 ? 1 : 3;
  endfunction
  function automatic bit m_vis(int d);
    return m_have[d] && cyc >= m_at[d];
  endfunction
  function automatic bit m_rdy(int d);
    return !rst && (!m_have[d] || (m_vis(d) && rsp_ready));
  endfunction
  task automatic chk(string n, int d, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s dut%0d cyc=%0d: got %0h expected %0h", n, d, cyc, act, exp);
    end
  endtask
  task automatic m_clear(int d);
    m_have[d] = 0; m_zero[d] = 0; m_err[d] = 0; m_at[d] = 0;
    m_res[d] = '0; m_a[d] = '0; m_b[d] = '0; m_sel[d] = '0; m_tag[d] = '0; m_ops[d] = '0;
  endtask
  // one clock: advance the model with the inputs seen at the edge, then compare on the falling edge
  task automatic step();
    bit acc [2], hs [2];
    for (int d = 0; d < 2; d++) begin
      acc[d] = req_valid && m_rdy(d);
      hs[d] = !rst && m_vis(d) && rsp_ready;
    end
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst) m_clear(d);
      else begin
        if (hs[d]) begin m_have[d] = 0; m_ops[d] = m_ops[d] + 16'd1; end
        if (acc[d]) begin
          m_have[d] = 1;
          m_tag[d] = req_tag;
          if (req_sel < 10) begin
            m_a[d] = req_a; m_b[d] = req_b; m_sel[d] = req_sel;
            m_res[d] = req_a + req_b; m_zero[d] = (req_a + req_b) == 0; m_err[d] = 0;
            m_at[d] = cyc + lat(d);
          end else begin
            m_res[d] = '0; m_zero[d] = 0; m_err[d] = 1; m_at[d] = cyc;
          end
        end
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("req_ready", d, rdy[d], m_rdy(d));
      chk("rsp_valid", d, rv[d], m_vis(d));
      chk("busy", d, busy[d], m_have[d]);
      chk("alu_a", d, alu_a[d], m_a[d]);
      chk("alu_b", d, alu_b[d], m_b[d]);
      chk("alu_sel", d, alu_sel[d], m_sel[d]);
      chk("ops_done", d, ops_done[d], m_ops[d]);
      if (m_vis(d)) begin
        chk("rsp_res", d, rr[d], m_res[d]);
        chk("rsp_tag", d, rt[d], m_tag[d]);
        chk("rsp_zero", d, rz[d], m_zero[d]);
        chk("rsp_err", d, re[d], m_err[d]);
      end
    end
  endtask
  task automatic do_op(vec_t v);
    bit seen [2];
    int t0;
    seen[0] = 0; seen[1] = 0;
    req_valid = 1; req_a = v.a; req_b = v.b; req_sel = v.sel; req_tag = v.tag; rsp_ready = 1;
    step();
    t0 = cyc;
    req_valid = 0;
    for (int t = 0; t < 8 && !(seen[0] && seen[1]); t++) begin
      for (int d = 0; d < 2; d++) if (rv[d] && !seen[d]) begin
        seen[d] = 1;
        chk("op_res", d, rr[d], v.res);
        chk("op_tag", d, rt[d], v.tag);
        chk("op_zero", d, rz[d], v.zero);
        chk("op_err", d, re[d], v.err);
        chk("op_latency", d, cyc - t0, v.err ? 0 : lat(d));
        if (v.err) chk("alu_sel_hold", d, alu_sel[d], last_sel);
      end
      if (!(seen[0] && seen[1])) step();
    end
    for (int d = 0; d < 2; d++) chk("op_seen", d, seen[d], 1);
    if (!v.err) last_sel = v.sel;
    step();
  endtask
  vec_t tbl [6];
  logic [TW-1:0] seq [2][2];
  int n [2];
  logic [15:0] ops0 [2];
  initial begin
    tbl[0] = '{a: 150, b: 78, sel: 9, tag: 3, res: 228, zero: 0, err: 0};
    tbl[1] = '{a: 0, b: 0, sel: 2, tag: 5, res: 0, zero: 1, err: 0};
    tbl[2] = '{a: 32'hFFFF_FFFF, b: 1, sel: 0, tag: 1, res: 0, zero: 1, err: 0};
    tbl[3] = '{a: 11, b: 22, sel: 12, tag: 7, res: 0, zero: 0, err: 1};
    tbl[4] = '{a: 5, b: 6, sel: 15, tag: 9, res: 0, zero: 0, err: 1};
    tbl[5] = '{a: 32'hDEAD_0000, b: 32'h0000_BEEF, sel: 5, tag: 15, res: 32'hDEAD_BEEF, zero: 0, err: 0};
    for (int d = 0; d < 2; d++) m_clear(d);
    last_sel = '0;
    rst = 1; req_valid = 0; req_a = '0; req_b = '0; req_sel = '0; req_tag = '0; rsp_ready = 1;
    @(negedge clk);
    step(); step();
    for (int d = 0; d < 2; d++) begin
      chk("reset_rsp_valid", d, rv[d], 0);
      chk("reset_req_ready", d, rdy[d], 0);
      chk("reset_ops", d, ops_done[d], 0);
    end
    rst = 0;
    step();
    for (int i = 0; i < 6; i++) do_op(tbl[i]);
    // backpressure: response must hold while a second request is ignored
    req_valid = 1; req_a = 7; req_b = 8; req_sel = 3; req_tag = 4; rsp_ready = 0;
    step();
    req_a = 100; req_tag = 5;
    repeat (8) step();
    for (int d = 0; d < 2; d++) begin
      chk("bp_valid", d, rv[d], 1);
      chk("bp_tag", d, rt[d], 4);
      chk("bp_res", d, rr[d], 15);
      chk("bp_req_ready", d, rdy[d], 0);
      ops0[d] = m_ops[d];
    end
    req_valid = 0; rsp_ready = 1;
    step();
    for (int d = 0; d < 2; d++) begin
      chk("bp_release_valid", d, rv[d], 0);
      chk("bp_release_ops", d, ops_done[d], ops0[d] + 16'd1);
    end
    step();
    // back-to-back: second request rides on the first response handshake
    n[0] = 0; n[1] = 0;
    req_valid = 1; req_a = 1; req_b = 2; req_sel = 0; req_tag = 1; rsp_ready = 1;
    step();
    req_a = 3; req_b = 4; req_sel = 1; req_tag = 2;
    for (int t = 0; t < 20 && !(n[0] == 2 && n[1] == 2); t++) begin
      for (int d = 0; d < 2; d++) if (rv[d] && n[d] < 2) begin seq[d][n[d]] = rt[d]; n[d]++; end
      if (!(n[0] == 2 && n[1] == 2)) step();
    end
    for (int d = 0; d < 2; d++) begin
      chk("b2b_count", d, n[d], 2);
      chk("b2b_first", d, seq[d][0], 1);
      chk("b2b_second", d, seq[d][1], 2);
    end
    req_valid = 0;
    repeat (6) step();
    // reset two edges into an operation aborts it
    req_valid = 1; req_a = 9; req_b = 9; req_sel = 1; req_tag = 6; rsp_ready = 1;
    step();
    req_valid = 0;
    step();
    rst = 1;
    step();
    for (int d = 0; d < 2; d++) begin
      chk("abort_valid", d, rv[d], 0);
      chk("abort_busy", d, busy[d], 0);
      chk("abort_req_ready", d, rdy[d], 0);
      chk("abort_res", d, rr[d], 0);
      chk("abort_tag", d, rt[d], 0);
      chk("abort_zero", d, rz[d], 0);
      chk("abort_err", d, re[d], 0);
      chk("abort_alu_a", d, alu_a[d], 0);
      chk("abort_alu_sel", d, alu_sel[d], 0);
      chk("abort_ops", d, ops_done[d], 0);
    end
    rst = 0;
    last_sel = '0;
    repeat (5) begin
      step();
      for (int d = 0; d < 2; d++) chk("abort_no_ghost", d, rv[d], 0);
    end
    do_op(tbl[0]);
    for (int i = 0; i < 1500; i++) begin
      rst = $urandom_range(0, 63) == 0;
      req_valid = $urandom_range(0, 1) == 1;
      req_a = $urandom_range(0, 7) == 0 ? '0 : W'($urandom);
      req_b = $urandom_range(0, 7) == 0 ? '0 : W'($urandom);
      req_sel = 4'($urandom_range(0, 15));
      req_tag = TW'($urandom);
      rsp_ready = $urandom_range(0, 9) < 7;
      step();
    end
    // counter wrap: illegal ops complete one per cycle
    rst = 1; req_valid = 0; rsp_ready = 1;
    step();
    rst = 0; req_valid = 1; req_sel = 12; req_tag = 8;
    repeat (65537) step();
    for (int d = 0; d < 2; d++) chk("ops_wrap", d, ops_done[d], 0);
    step();
    for (int d = 0; d < 2; d++) chk("ops_after_wrap", d, ops_done[d], 1);
    req_valid = 0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
